// File: rtl/instruction_decode_pkg.sv
// Shared pipeline definitions: widths, opcodes and ALU control encodings used by decode and EX.
package pipeline_pkg;

  localparam int DATA_W     = 20;
  localparam int REG_ADDR_W = 3;
  localparam int INSTR_W    = 20;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_OR  = 4'b0001,
    OP_AND = 4'b0010,
    OP_NOT = 4'b0011
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_OR  = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_ctrl_e;

  typedef struct packed {
    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [6:0]            unused_lo;
  } instr_t;

  function automatic alu_ctrl_e op_to_alu(input logic [3:0] op);
    case (op)
      OP_OR:   return ALU_OR;
      OP_AND:  return ALU_AND;
      OP_NOT:  return ALU_NOT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch, writeback and EX-side signals of the decode stage; master = pipeline side, slave = decode.
interface instruction_decode_if #(parameter int DATA_W = pipeline_pkg::DATA_W);
  import pipeline_pkg::*;

  logic                  inValid;
  logic [INSTR_W-1:0]    inInstr;
  logic                  inReady;
  logic                  flush;
  logic                  wbEnable;
  logic [REG_ADDR_W-1:0] wbAddr;
  logic [DATA_W-1:0]     wbData;
  logic                  exValid;
  logic [1:0]            exControl;
  logic [DATA_W-1:0]     exOpA;
  logic [DATA_W-1:0]     exOpB;
  logic [REG_ADDR_W-1:0] exRd;
  logic                  exRegWrite;

  modport master (
    output inValid, inInstr, flush, wbEnable, wbAddr, wbData,
    input  inReady, exValid, exControl, exOpA, exOpB, exRd, exRegWrite
  );

  modport slave (
    input  inValid, inInstr, flush, wbEnable, wbAddr, wbData,
    output inReady, exValid, exControl, exOpA, exOpB, exRd, exRegWrite
  );

endinterface

// File: rtl/instruction_decode_register_file.sv
// Two-read/one-write register file, r0 hardwired to zero.
// Define ID_WB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module register_file #(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int NUM_REGS = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                we,
  input  logic [pipeline_pkg::REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]                   wdata,
  input  logic [pipeline_pkg::REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]                   rdata_a,
  input  logic [pipeline_pkg::REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]                   rdata_b
);
  import pipeline_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
`ifdef ID_WB_BYPASS_EN
    if (we && waddr == raddr_a) rdata_a = wdata;
    if (we && waddr == raddr_b) rdata_b = wdata;
`endif
    // r0 wins over the bypass so a write to r0 never leaks through
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: scoreboard hazard check, operand read and the EX pipeline register.
// Define ID_WB_BYPASS_EN to let a same-cycle writeback clear a hazard and supply the operand.
module instruction_decode #(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int NUM_REGS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  instruction_decode_if.slave  id
);
  import pipeline_pkg::*;

  instr_t              instr;
  alu_ctrl_e           ctrl_p0;
  logic                is_alu_p0;
  logic                hazard;
  logic                issue;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_eff;
  logic [DATA_W-1:0]   rdata_a;
  logic [DATA_W-1:0]   rdata_b;
  logic                unused_bits;

  logic                  vld_p1;
  logic [1:0]            ctrl_p1;
  logic [DATA_W-1:0]     opa_p1;
  logic [DATA_W-1:0]     opb_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic                  rw_p1;

  assign instr       = id.inInstr;
  assign unused_bits = ^instr.unused_lo;

  register_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_register_file (
    .clock   (clock),
    .reset   (reset),
    .we      (id.wbEnable),
    .waddr   (id.wbAddr),
    .wdata   (id.wbData),
    .raddr_a (instr.rs),
    .rdata_a (rdata_a),
    .raddr_b (instr.rt),
    .rdata_b (rdata_b)
  );

  // ---- p0: decode and hazard check ----
  always_comb begin
    pend_eff = pending;
`ifdef ID_WB_BYPASS_EN
    if (id.wbEnable) pend_eff[id.wbAddr] = 1'b0;
`endif
  end

  assign is_alu_p0 = (instr.opcode[3:2] == 2'b00);
  assign ctrl_p0   = is_alu_p0 ? op_to_alu(instr.opcode) : ALU_ADD;
  assign hazard    = id.inValid &&
                     (pend_eff[instr.rs] ||
                      (instr.opcode != OP_NOT && pend_eff[instr.rt]) ||
                      pend_eff[instr.rd]);
  assign id.inReady = !hazard;
  assign issue      = id.inValid && !hazard && !id.flush;

  // Issue is checked first so a same-cycle set and clear leaves the bit set
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (issue && is_alu_p0 && int'(instr.rd) == i)
          pending[i] <= 1'b1;
        else if (id.wbEnable && int'(id.wbAddr) == i)
          pending[i] <= 1'b0;
      end
      pending[0] <= 1'b0;
    end
  end

  // ---- p1: EX register ----
  always_ff @(posedge clock) begin
    if (reset || !issue) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= ALU_ADD;
      opa_p1  <= '0;
      opb_p1  <= '0;
      rd_p1   <= '0;
      rw_p1   <= 1'b0;
    end else begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= ctrl_p0;
      opa_p1  <= rdata_a;
      opb_p1  <= rdata_b;
      rd_p1   <= instr.rd;
      rw_p1   <= is_alu_p0;
    end
  end

  assign id.exValid    = vld_p1;
  assign id.exControl  = ctrl_p1;
  assign id.exOpA      = opa_p1;
  assign id.exOpB      = opb_p1;
  assign id.exRd       = rd_p1;
  assign id.exRegWrite = rw_p1;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode; honours ID_WB_BYPASS_EN when defined for the build.
module tb_instruction_decode;
  import pipeline_pkg::*;

  localparam int DW = 20;

  typedef struct packed {
    logic          vld;
    logic [1:0]    ctrl;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [2:0]    rd;
    logic          rw;
  } ex_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  instruction_decode_if #(.DATA_W(DW)) bus();

  instruction_decode #(.DATA_W(DW), .NUM_REGS(8)) dut (
    .clock (clock),
    .reset (reset),
    .id    (bus)
  );

  always #5 clock = ~clock;

  int      errors = 0;
  int      checks = 0;
  ex_t     expq[$];
  ex_t     exp_ex;
  logic    exp_rdy;
  logic [DW-1:0] mregs [8];
  logic          mpend [8];

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 7'h55};
  endfunction

  function automatic ex_t act_ex();
    return {bus.exValid, bus.exControl, bus.exOpA, bus.exOpB, bus.exRd, bus.exRegWrite};
  endfunction

  // Drive one cycle of inputs, predict inReady now and the EX contents after the next edge
  task automatic apply(input logic rst, input logic v, input logic [19:0] ins, input logic fl,
                       input logic wbe, input logic [2:0] wba, input logic [DW-1:0] wbd);
    logic [3:0] op;
    logic [2:0] rd, rs, rt;
    logic       pe [8];
    logic       haz, iss, alu;
    ex_t        e;
    reset        = rst;
    bus.inValid  = v;
    bus.inInstr  = ins;
    bus.flush    = fl;
    bus.wbEnable = wbe;
    bus.wbAddr   = wba;
    bus.wbData   = wbd;
    #1;
    op = ins[19:16]; rd = ins[15:13]; rs = ins[12:10]; rt = ins[9:7];
    for (int i = 0; i < 8; i++) pe[i] = mpend[i];
`ifdef ID_WB_BYPASS_EN
    if (wbe) pe[wba] = 1'b0;
`endif
    haz     = v && (pe[rs] || (op != 4'b0011 && pe[rt]) || pe[rd]);
    exp_rdy = !haz;
    iss     = v && !haz && !fl && !rst;
    alu     = (op < 4'd4);
    e = '0;
    if (iss) begin
      e.vld  = 1'b1;
      e.ctrl = alu ? op[1:0] : 2'b00;
      e.opa  = (rs == 3'd0) ? '0 : mregs[rs];
      e.opb  = (rt == 3'd0) ? '0 : mregs[rt];
`ifdef ID_WB_BYPASS_EN
      if (wbe && wba == rs && rs != 3'd0) e.opa = wbd;
      if (wbe && wba == rt && rt != 3'd0) e.opb = wbd;
`endif
      e.rd   = rd;
      e.rw   = alu;
    end
    expq.push_back(e);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin mregs[i] = '0; mpend[i] = 1'b0; end
    end else begin
      if (wbe) mpend[wba] = 1'b0;
      if (iss && alu && rd != 3'd0) mpend[rd] = 1'b1;
      if (wbe && wba != 3'd0) mregs[wba] = wbd;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    exp_ex = (expq.size() > 0) ? expq.pop_front() : '0;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 3'd0, '0);
    tick();
  endtask

  task automatic wb(input logic [2:0] a, input logic [DW-1:0] d);
    apply(1'b0, 1'b0, 20'h0, 1'b0, 1'b1, a, d);
    tick();
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 3'd0, '0); tick();
    apply(1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 3'd0, '0); tick();
    checks++;
    if (act_ex() !== ex_t'(0)) begin
      errors++; $display("FAIL reset_ex act=%h exp=0", act_ex());
    end
    apply(1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 3'd0, '0);
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++; $display("FAIL reset_ready act=%b exp=1", bus.inReady);
    end
    tick();
    checks++;
    if (act_ex() !== exp_ex) begin
      errors++; $display("FAIL reset_idle act=%h exp=%h", act_ex(), exp_ex);
    end
  endtask

  task automatic test_add();
    ex_t want;
    wb(3'd2, 20'd5);
    wb(3'd3, 20'd7);
    apply(1'b0, 1'b1, mk(4'b0000, 3'd1, 3'd2, 3'd3), 1'b0, 1'b0, 3'd0, '0);
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++; $display("FAIL add_ready act=%b exp=1", bus.inReady);
    end
    tick();
    want = '{vld:1'b1, ctrl:2'b00, opa:20'd5, opb:20'd7, rd:3'd1, rw:1'b1};
    checks++;
    if (act_ex() !== want) begin
      errors++; $display("FAIL add_ex act=%h exp=%h", act_ex(), want);
    end
  endtask

  task automatic test_hazard();
    int issue_cyc = -1;
    int want_cyc;
    logic held = 1'b1;
`ifdef ID_WB_BYPASS_EN
    want_cyc = 3;
`else
    want_cyc = 4;
`endif
    for (int c = 0; c < 6; c++) begin
      apply(1'b0, held, mk(4'b0001, 3'd4, 3'd1, 3'd2), 1'b0, (c == 3), 3'd1, 20'h00012);
      checks++;
      if (bus.inReady !== exp_rdy) begin
        errors++; $display("FAIL hazard_ready c=%0d act=%b exp=%b", c, bus.inReady, exp_rdy);
      end
      if (held && exp_rdy) held = 1'b0;
      tick();
      checks++;
      if (act_ex() !== exp_ex) begin
        errors++; $display("FAIL hazard_ex c=%0d act=%h exp=%h", c, act_ex(), exp_ex);
      end
      if (bus.exValid === 1'b1 && issue_cyc < 0) issue_cyc = c;
    end
    checks++;
    if (issue_cyc != want_cyc) begin
      errors++; $display("FAIL hazard_issue_cycle act=%0d exp=%0d", issue_cyc, want_cyc);
    end
    wb(3'd4, 20'h00044);
  endtask

  task automatic test_r0();
    wb(3'd0, 20'hFFFFF);
    apply(1'b0, 1'b1, mk(4'b0000, 3'd6, 3'd0, 3'd0), 1'b0, 1'b0, 3'd0, '0);
    tick();
    checks++;
    if (bus.exOpA !== 20'd0 || bus.exValid !== 1'b1) begin
      errors++; $display("FAIL r0_read act=%h/%b exp=0/1", bus.exOpA, bus.exValid);
    end
    checks++;
    if (act_ex() !== exp_ex) begin
      errors++; $display("FAIL r0_ex act=%h exp=%h", act_ex(), exp_ex);
    end
    wb(3'd6, 20'd0);
  endtask

  task automatic test_flush();
    apply(1'b0, 1'b1, mk(4'b0010, 3'd5, 3'd2, 3'd3), 1'b1, 1'b0, 3'd0, '0);
    tick();
    checks++;
    if (act_ex() !== ex_t'(0)) begin
      errors++; $display("FAIL flush_bubble act=%h exp=0", act_ex());
    end
    apply(1'b0, 1'b1, mk(4'b0001, 3'd7, 3'd5, 3'd5), 1'b0, 1'b0, 3'd0, '0);
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++; $display("FAIL flush_r5_ready act=%b exp=1", bus.inReady);
    end
    tick();
    checks++;
    if (act_ex() !== exp_ex) begin
      errors++; $display("FAIL flush_follow act=%h exp=%h", act_ex(), exp_ex);
    end
    // flush alongside a writeback: the write and pending clear still land
    apply(1'b0, 1'b1, mk(4'b0010, 3'd5, 3'd2, 3'd3), 1'b1, 1'b1, 3'd7, 20'h00077);
    tick();
    apply(1'b0, 1'b1, mk(4'b0000, 3'd6, 3'd7, 3'd7), 1'b0, 1'b0, 3'd0, '0);
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++; $display("FAIL flush_wb_ready act=%b exp=1", bus.inReady);
    end
    tick();
    checks++;
    if (act_ex() !== exp_ex) begin
      errors++; $display("FAIL flush_wb_ex act=%h exp=%h", act_ex(), exp_ex);
    end
    wb(3'd6, 20'd0);
  endtask

  task automatic test_not_rt();
    apply(1'b0, 1'b1, mk(4'b0000, 3'd1, 3'd2, 3'd3), 1'b0, 1'b0, 3'd0, '0);
    tick();
    apply(1'b0, 1'b1, mk(4'b0011, 3'd2, 3'd3, 3'd1), 1'b0, 1'b0, 3'd0, '0);
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++; $display("FAIL not_rt_ready act=%b exp=1", bus.inReady);
    end
    tick();
    checks++;
    if (act_ex() !== exp_ex) begin
      errors++; $display("FAIL not_rt_ex act=%h exp=%h", act_ex(), exp_ex);
    end
    wb(3'd1, 20'h00012);
    wb(3'd2, 20'd5);
  endtask

  task automatic test_same_cycle();
    apply(1'b0, 1'b1, mk(4'b0000, 3'd1, 3'd2, 3'd3), 1'b0, 1'b1, 3'd1, 20'h00009);
    tick();
    apply(1'b0, 1'b1, mk(4'b0001, 3'd4, 3'd1, 3'd2), 1'b0, 1'b0, 3'd0, '0);
    checks++;
    if (bus.inReady !== 1'b0) begin
      errors++; $display("FAIL same_cycle_ready act=%b exp=0", bus.inReady);
    end
    tick();
    checks++;
    if (act_ex() !== exp_ex) begin
      errors++; $display("FAIL same_cycle_ex act=%h exp=%h", act_ex(), exp_ex);
    end
    wb(3'd1, 20'h00009);
  endtask

  task automatic test_reset_stall();
    apply(1'b0, 1'b1, mk(4'b0000, 3'd1, 3'd2, 3'd3), 1'b0, 1'b0, 3'd0, '0);
    tick();
    apply(1'b0, 1'b1, mk(4'b0001, 3'd4, 3'd1, 3'd2), 1'b0, 1'b0, 3'd0, '0);
    tick();
    apply(1'b1, 1'b1, mk(4'b0001, 3'd4, 3'd1, 3'd2), 1'b0, 1'b0, 3'd0, '0);
    tick();
    checks++;
    if (act_ex() !== ex_t'(0)) begin
      errors++; $display("FAIL rst_stall_ex act=%h exp=0", act_ex());
    end
    apply(1'b0, 1'b1, mk(4'b0001, 3'd4, 3'd1, 3'd2), 1'b0, 1'b0, 3'd0, '0);
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++; $display("FAIL rst_stall_ready act=%b exp=1", bus.inReady);
    end
    tick();
    checks++;
    if (act_ex() !== exp_ex) begin
      errors++; $display("FAIL rst_stall_issue act=%h exp=%h", act_ex(), exp_ex);
    end
    wb(3'd4, 20'd0);
  endtask

  task automatic test_nop();
    ex_t want;
    apply(1'b0, 1'b1, mk(4'b1010, 3'd3, 3'd0, 3'd0), 1'b0, 1'b0, 3'd0, '0);
    tick();
    want = '{vld:1'b1, ctrl:2'b00, opa:20'd0, opb:20'd0, rd:3'd3, rw:1'b0};
    checks++;
    if (act_ex() !== want) begin
      errors++; $display("FAIL nop_ex act=%h exp=%h", act_ex(), want);
    end
    apply(1'b0, 1'b1, mk(4'b0000, 3'd3, 3'd3, 3'd3), 1'b0, 1'b0, 3'd0, '0);
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++; $display("FAIL nop_no_pending act=%b exp=1", bus.inReady);
    end
    tick();
    wb(3'd3, 20'd0);
  endtask

  task automatic test_back_to_back();
    logic [19:0] ins;
    logic v, fl, wbe;
    for (int c = 0; c < 300; c++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 3) != 0) ins[19:18] = 2'b00;
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      wbe = ($urandom_range(0, 2) == 0);
      apply(1'b0, v, ins, fl, wbe, 3'($urandom_range(0, 7)), 20'($urandom));
      checks++;
      if (bus.inReady !== exp_rdy) begin
        errors++; $display("FAIL b2b_ready c=%0d act=%b exp=%b", c, bus.inReady, exp_rdy);
      end
      tick();
      checks++;
      if (act_ex() !== exp_ex) begin
        errors++; $display("FAIL b2b_ex c=%0d act=%h exp=%h", c, act_ex(), exp_ex);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin mregs[i] = '0; mpend[i] = 1'b0; end
    bus.inValid = 1'b0; bus.inInstr = '0; bus.flush = 1'b0;
    bus.wbEnable = 1'b0; bus.wbAddr = '0; bus.wbData = '0;
    test_reset();
    test_add();
    test_hazard();
    test_r0();
    test_flush();
    test_not_rt();
    test_same_cycle();
    test_reset_stall();
    test_nop();
    test_back_to_back();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
